muldiv_unit: RTL

- Parametrised iterative multiply/divide execution unit for the RV32M extension; successor to the single-cycle ALU control path.
- Decodes funct3 internally into one of the 8 M-extension operations.
- Computes the result over multiple cycles using radix-2 shift-add (multiply) or restoring division (divide).
- Sits beside the ALU in the execute stage; the stall logic uses ready_o and valid_o to hold the pipeline while the unit is busy.

---
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Iterative RV32M multiply/divide execution unit
//
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   flush_i          synchronous abort of any in-flight operation
//   valid_i/ready_o  request handshake (funct3_i, op_a_i, op_b_i)
//   valid_o/ready_i  result handshake (result_o, registered)
module muldiv_unit #(
    parameter int XLEN          = 32,
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          f3_q;
    logic                a_neg_q, neg_q, div0_q;
    logic [XLEN-1:0]     opnd_q;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q;       // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
    logic [XLEN-1:0]     result_q;

    // Request decode on the raw inputs, used only in the acceptance cycle.
    logic            accept;
    logic            is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic            div0_in, ovf_in, special_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;

    always_comb begin
        is_div_in   = funct3_i[2];
        a_signed_in = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
        b_signed_in = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        a_neg_in    = a_signed_in && op_a_i[XLEN-1];
        b_neg_in    = b_signed_in && op_b_i[XLEN-1];
        a_mag_in    = a_neg_in ? -op_a_i : op_a_i;
        b_mag_in    = b_neg_in ? -op_b_i : op_b_i;
        div0_in     = is_div_in && (op_b_i == '0);
        ovf_in      = is_div_in && !funct3_i[0] &&
                      (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
        special_in  = EARLY_SPECIAL && (div0_in || ovf_in);
        // funct3_i[1] distinguishes remainder from quotient.
        if (div0_in) special_res = funct3_i[1] ? op_a_i : '1;
        else         special_res = funct3_i[1] ? '0 : op_a_i;
    end

    assign accept = (state_q == S_IDLE) && valid_i && !flush_i;

    // One iteration of the selected algorithm.
    logic [XLEN-1:0]   acc_hi, acc_lo;
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        acc_hi    = acc_q[2*XLEN-1:XLEN];
        acc_lo    = acc_q[XLEN-1:0];
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (f3_q[2]) begin
            // The partial remainder stays below the divisor, so whenever the
            // shifted value overflows XLEN bits the trial subtraction succeeds.
            if (!div_trial[XLEN]) acc_step = {div_trial[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
            else                  acc_step = {div_shift[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_lo[XLEN-1:1]};
        end
    end

    // Sign correction and field select.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        // A signed divide by zero must still yield all ones, so skip negation.
        quot_fix = (neg_q && !div0_q) ? -acc_lo : acc_lo;
        rem_fix  = a_neg_q ? -acc_hi : acc_hi;
        case (f3_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quot_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // FSM: state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (valid_i) state_d = special_in ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // FSM: outputs.
    always_comb begin
        ready_o = (state_q == S_IDLE);
        valid_o = (state_q == S_DONE);
    end

    assign result_o = result_q;

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            a_neg_q  <= 1'b0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            f3_q    <= funct3_i;
            a_neg_q <= a_neg_in;
            neg_q   <= a_neg_in ^ b_neg_in;
            div0_q  <= div0_in;
            cnt_q   <= CNT_INIT;
            opnd_q  <= is_div_in ? b_mag_in : a_mag_in;
            acc_q   <= {{XLEN{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
            if (special_in) result_q <= special_res;
        end else if (state_q == S_CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CW'(1);
        end else if (state_q == S_FIX && !flush_i) begin
            result_q <= fix_res;
        end
    end

endmodule
